// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary-to-BCD converter, shift-and-add-3, one bit per clock
module bin2bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W-1:0]          bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    // ceil(W * log10(2)) in integer arithmetic
    localparam int MIN_DIGITS = (W * 30103 + 99999) / 100000;
    localparam int CW         = $clog2(W + 1);
    localparam int SW         = 4 * DIGITS;

    generate
        if ((W < 4) || (W > 32)) begin : g_bad_width
            $error("bin2bcd_seq: W must be in 4..32");
        end
        if (DIGITS < MIN_DIGITS) begin : g_bad_digits
            $error("bin2bcd_seq: DIGITS too small for W");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [W-1:0]    bin_sr;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   adjusted;
    logic [SW-1:0]   shifted;
    logic [CW-1:0]   cnt;
    logic            load;
    logic            step;
    logic            finish;

    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adjusted[SW-2:0], bin_sr[W-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == CW'(1)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The last shift bypasses the scratch register and lands straight in bcd_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd_out <= '0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                bin_sr  <= bin_in;
                scratch <= '0;
                cnt     <= CW'(W);
            end else if (step) begin
                bin_sr  <= {bin_sr[W-2:0], 1'b0};
                scratch <= shifted;
                cnt     <= cnt - CW'(1);
            end
            if (finish) begin
                bcd_out <= shifted;
            end
        end
    end

    assign busy = (state == SHIFT);

endmodule
